// File: rtl/mau_pkg.sv
// mau_pkg: access-size encodings, FSM states and the misalignment predicate
// shared by mem_access_unit and mau_align.
package mau_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_WORD_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // The reserved encoding 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input size_e size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mau_align.sv
// mau_align: combinational store merge (read-modify-write) and load
// zero/sign extension for mem_access_unit.
module mau_align
    import mau_pkg::*;
(
    input  size_e               size,
    input  logic                sign_ext,
    input  logic [WORD_W-1:0]   rdata,
    input  logic [WORD_W-1:0]   wdata,
    output logic [WORD_W-1:0]   merged,
    output logic [WORD_W-1:0]   extended
);

    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        merged   = wdata;
        extended = rdata;
        case (size)
            SIZE_BYTE: begin
                merged   = {rdata[31:8], wdata[7:0]};
                extended = {{24{sign_ext & rdata[7]}}, rdata[7:0]};
            end
            SIZE_HALF: begin
                merged   = {rdata[31:16], wdata[15:0]};
                extended = {{16{sign_ext & rdata[15]}}, rdata[15:0]};
            end
            default: begin
                merged   = wdata;
                extended = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store front end to a combinational-read RAM,
// with read-modify-write for sub-word stores. Optional MAU_MISALIGN_TRAP_EN
// turns misaligned requests into an immediate error response.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr_r,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] ram_addr_w,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we
);

    state_e              state_q,  state_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    size_e               size_q,   size_d;
    logic                signed_q, signed_d;
    logic                we_q,     we_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
`ifdef MAU_MISALIGN_TRAP_EN
    logic                err_q,    err_d;
`endif

    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   extended;

    mau_align u_align (
        .size     (size_q),
        .sign_ext (signed_q),
        .rdata    (ram_rdata),
        .wdata    (wdata_q),
        .merged   (merged),
        .extended (extended)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef MAU_MISALIGN_TRAP_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = size_e'(req_size);
                    signed_d = req_signed;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    state_d  = (req_we && is_word(size_e'(req_size))) ? ST_WRITE : ST_READ;
`ifdef MAU_MISALIGN_TRAP_EN
                    err_d    = 1'b0;
                    if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            // The merged word overwrites wdata_q so WRITE drives it straight out.
            ST_READ: begin
                if (we_q) begin
                    wdata_d = merged;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = extended;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef MAU_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    // Outputs are decoded from flops only, so reset clears them asynchronously.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign ram_we     = (state_q == ST_WRITE);
    assign ram_addr_r = addr_q;
    assign ram_addr_w = addr_q;
    assign ram_wdata  = wdata_q;
    assign resp_rdata = rdata_q;
`ifdef MAU_MISALIGN_TRAP_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store traffic against a byte-array
// RAM and a byte-level reference model of memory and expected responses.
module tb_mem_access_unit;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ram_addr_r, ram_rdata, ram_addr_w, ram_wdata;
    logic        ram_we;

    logic [7:0]  ram   [0:4095];
    logic [7:0]  model [0:4095];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          we_pulses = 0;

    always #5 m_clock = ~m_clock;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_addr_r (ram_addr_r),
        .ram_rdata  (ram_rdata),
        .ram_addr_w (ram_addr_w),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we)
    );

    logic [11:0] ra, wa;
    assign ra = ram_addr_r[11:0];
    assign wa = ram_addr_w[11:0];
    assign ram_rdata = {ram[ra + 12'd3], ram[ra + 12'd2], ram[ra + 12'd1], ram[ra]};

    always @(posedge m_clock) begin
        if (ram_we) begin
            ram[wa]          <= ram_wdata[7:0];
            ram[wa + 12'd1]  <= ram_wdata[15:8];
            ram[wa + 12'd2]  <= ram_wdata[23:16];
            ram[wa + 12'd3]  <= ram_wdata[31:24];
            we_pulses        <= we_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input bit use_model, input logic [11:0] a);
        logic [31:0] w = 0;
        for (int i = 0; i < 4; i++) begin
            logic [11:0] ai = a + 12'(i);
            w = w + ((use_model ? 32'(model[ai]) : 32'(ram[ai])) << (8 * i));
        end
        return w;
    endfunction

    // Expected load value from the spec rules, using plain arithmetic.
    function automatic logic [31:0] exp_load(input logic [1:0] size, input bit sgn, input logic [11:0] a);
        logic [31:0] w = word_at(1'b1, a);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = w % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = w % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    task automatic poke(input logic [11:0] a, input logic [31:0] w);
        logic [31:0] t = w;
        for (int i = 0; i < 4; i++) begin
            ram[a + 12'(i)]   = t[7:0];
            model[a + 12'(i)] = t[7:0];
            t = t >> 8;
        end
    endtask

    task automatic run_txn(input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        bit          trap = 1'b0;
        int          exp_lat, lat, pulses0, nbytes;
        logic [31:0] exp_rd, t;
`ifdef MAU_MISALIGN_TRAP_EN
        trap = misaligned(size, addr);
`endif
        if (trap)               exp_lat = 1;
        else if (!we)           exp_lat = 2;
        else if (size >= 2'd2)  exp_lat = 2;
        else                    exp_lat = 3;
        exp_rd = (we || trap) ? 32'h0 : exp_load(size, sgn, addr[11:0]);

        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge m_clock);
        #1;
        pulses0 = we_pulses;
        req_valid = 1'b0;
        req_wdata = $urandom; req_addr = $urandom; req_size = 2'($urandom);
        req_we = 1'($urandom); req_signed = 1'($urandom);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            check("req_ready_busy", {31'b0, req_ready}, 32'd0);
            @(posedge m_clock);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", {31'b0, resp_err}, {31'b0, trap});
        check("we_pulses", we_pulses - pulses0, (we && !trap) ? 32'd1 : 32'd0);

        if (we && !trap) begin
            nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            t = wdata;
            for (int i = 0; i < nbytes; i++) begin
                model[addr[11:0] + 12'(i)] = t[7:0];
                t = t >> 8;
            end
        end

        for (int i = 0; i < stall; i++) begin
            @(posedge m_clock);
            #1;
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, exp_rd);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
        end
        check("stall_no_we", we_pulses - pulses0, (we && !trap) ? 32'd1 : 32'd0);
        resp_ready = 1'b1;
        @(posedge m_clock);
        #1;
        resp_ready = 1'b0;
        check("back_to_idle", {31'b0, req_ready}, 32'd1);
        check("resp_dropped", {31'b0, resp_valid}, 32'd0);
        check("mem_word", word_at(1'b0, addr[11:0]), word_at(1'b1, addr[11:0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'b0, req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_ram_we"},     {31'b0, ram_we},     32'd0);
        check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        check({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
        check({tag, "_ram_addr_r"}, ram_addr_r,          32'd0);
        check({tag, "_ram_addr_w"}, ram_addr_w,          32'd0);
        check({tag, "_ram_wdata"},  ram_wdata,           32'd0);
    endtask

    initial begin
        int pulses0;
        logic [1:0]  sz;
        logic [31:0] a;

        p_reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]   = 8'($urandom);
            model[i] = ram[i];
        end

        #12;
        check_reset_outputs("reset");
        @(negedge m_clock);
        p_reset = 1'b1;

        // Word store then word load at 0x100.
        run_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);

        // Byte store merges into the existing word.
        poke(12'h200, 32'h11223344);
        run_txn(1'b1, 2'd0, 1'b0, 32'h200, 32'h000000AA, 0);
        check("rmw_word", word_at(1'b0, 12'h200), 32'h112233AA);

        // Extension of sub-word loads.
        poke(12'h300, 32'h000080F0);
        run_txn(1'b0, 2'd0, 1'b1, 32'h300, 32'h0, 0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h300, 32'h0, 0);
        run_txn(1'b0, 2'd1, 1'b1, 32'h300, 32'h0, 0);

        // Misaligned half store, then a long response stall.
        run_txn(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000BEEF, 0);
        run_txn(1'b0, 2'd3, 1'b1, 32'h200, 32'h0, 5);

        // Reset dropped while the unit is in WRITE.
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h400;
        req_wdata = 32'hCAFEF00D;
        @(posedge m_clock);
        #1;
        req_valid = 1'b0;
        pulses0 = we_pulses;
        check("pre_reset_we", {31'b0, ram_we}, 32'd1);
        #2;
        p_reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge m_clock);
        #1;
        check("midrst_no_write", we_pulses - pulses0, 32'd0);
        @(negedge m_clock);
        p_reset = 1'b1;
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0);

        // Randomized traffic, mixing aligned and misaligned addresses.
        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom);
            a  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFC;
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
